lab1_imul_msg_driver: RTL
=========================

# lab1_imul_msg_driver

Self-checking request initiator and response consumer for the lab1 integer multiplier's latency-insensitive val/rdy streams. It generates pseudo-random 32-bit operand pairs and sends them as 64-bit requests to the multiplier's input stream. It accepts 32-bit products from the multiplier's output stream and checks each one in order against an internally computed expected value. It sits beside any `lab1_imul_*` design in hardware harnesses and FPGA smoke tests, replacing the software source/sink.

## Interface
- `SEED`, 32'h0000_0001, initial LFSR state; zero is forced to 32'h1
- `FIFO_DEPTH`, 4, in-flight expected-product entries; power of two, 2..16
- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-high
- `start`  input  1  begin a run; sampled only in IDLE
- `num_msgs`  input  16  messages in the run; latched on `start`
- `req_val`  output  1  request valid (drives DUT `istream_val`)
- `req_rdy`  input  1  DUT ready (from DUT `istream_rdy`)
- `req_msg`  output  64  `{a, b}`, with a in [63:32] and b in [31:0]
- `resp_val`  input  1  DUT product valid (from DUT `ostream_val`)
- `resp_rdy`  output  1  driver ready (drives DUT `ostream_rdy`)
- `resp_msg`  input  32  DUT product
- `done`  output  1  run complete; held until next `start` or `reset`
- `pass_count`  output  16  responses that matched
- `fail_count`  output  16  responses that mismatched
- `error`  output  1  sticky; set on the first mismatch of a run

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN when `start`=1:
  - latch `num_msgs`;
  - clear the sent, received, pass and fail counters;
  - clear `error` and `done`.
- IDLE → DONE directly if `start`=1 and `num_msgs`=0.
- RUN → DONE in the cycle after received count reaches the latched `num_msgs`.
- DONE → RUN (or DONE if `num_msgs`=0) on `start`=1.
- `start` is ignored while in RUN.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right.
  - It advances exactly once per accepted request (`req_val & req_rdy`).
  - It keeps its state across runs and reloads `SEED` only on `reset`.
- Operands: a = lfsr, b = {lfsr[15:0], lfsr[31:16]}.
- Requests: `req_val` = RUN & (sent < num) & !fifo_full.
  - `req_msg` is stable while `req_val`=1 and `req_rdy`=0.
  - On each accepted request, push (a*b)[31:0] into the expected FIFO and increment sent.
- Responses: `resp_rdy` = RUN & !fifo_empty.
  - On each accepted response, pop the FIFO head.
  - If `resp_msg` equals the head, increment `pass_count`; otherwise increment `fail_count` and set `error`.
  - Increment received in both cases.
- Arithmetic: the product is the low 32 bits of an unsigned 32x32 multiply, identical to the DUT's contract.
- Counters are 16 bits; `num_msgs` ≤ 65535, so they never wrap.
- FIFO boundaries:
  - Push is blocked when full, even if a pop occurs in the same cycle.
  - A pop requires a non-empty FIFO; there is no push-to-pop bypass.
  - A simultaneous push and pop on a non-full, non-empty FIFO is allowed; occupancy is unchanged.

## Timing
- Reset values: FSM IDLE, `req_val`=0, `resp_rdy`=0, `done`=0, `pass_count`=0, `fail_count`=0, `error`=0, FIFO empty, LFSR=`SEED`.
- `req_msg` is don't-care while `req_val`=0.
- `reset` asserted mid-run has the same effect as at power-up: the FSM returns to IDLE next cycle and in-flight expectations are discarded.
- `start` at edge N gives RUN in cycle N+1, with `req_val`=1 in cycle N+1.
- Throughput is one request per cycle until FIFO_DEPTH requests are outstanding.
- Last matching response accepted at edge M gives `done`=1 in cycle M+1, with counters final in cycle M+1.
- All outputs are registered or derived from registered state only; there is no combinational path from `req_rdy` or `resp_val` to any output.

## Configuration
- `LAB1_IMUL_MSG_DRIVER_STALL_EN`:
  - When defined, a separate 8-bit LFSR (mask 8'hB8, seed 8'h5A, advancing every cycle) gates both streams.
  - `req_val` and `resp_rdy` are additionally ANDed with !stall, where stall = lfsr8[1:0]==2'b00, giving about 25% stall cycles.
  - Stalls are applied only before a handshake; `req_val` never drops once it is high and `req_rdy` is low.
- When undefined, no stall logic exists and the streams run at full rate as specified above.

## Test plan
- Reset, then `start` with `num_msgs`=1 and `SEED`=1, DUT ideal:
  - `req_msg`=64'h0000_0001_0001_0000;
  - DUT returns 32'h0001_0000, giving `pass_count`=1, `fail_count`=0, `done`=1, `error`=0.
- `num_msgs`=0 → `done`=1 one cycle after `start`, counts 0, and no `req_val` ever.
- DUT responds 32'hDEAD_BEEF to a 3-message run:
  - `fail_count`=3 and `error`=1;
  - a following `start` clears `error` and the counts.
- DUT holds `resp_val`=0 for 200 cycles with `num_msgs`=8 and `FIFO_DEPTH`=4:
  - exactly 4 requests are accepted, then `req_val`=0;
  - the run resumes correctly, ending with `pass_count`=8.
- `req_rdy` low for 10 cycles → `req_msg` and `req_val` stay constant and the LFSR does not advance.
- `reset` asserted mid-run after 2 of 5 requests:
  - outputs return to reset values;
  - the next run's first `req_msg` again equals 64'h0000_0001_0001_0000.

Source files
------------

// File: rtl/lab1_imul_msg_driver.sv
// Request generator and in-order response checker for the lab1 imul val/rdy streams.
// Define LAB1_IMUL_MSG_DRIVER_STALL_EN to add pseudo-random stalls on both streams.
module lab1_imul_msg_driver #(
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_msgs,
    output logic        req_val,
    input  logic        req_rdy,
    output logic [63:0] req_msg,
    input  logic        resp_val,
    output logic        resp_rdy,
    input  logic [31:0] resp_msg,
    output logic        done,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic        error
);

    localparam int unsigned     PtrW     = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]     LfsrMask = 32'h8020_0003;
    localparam logic [31:0]     SeedInit = (SEED == 32'h0) ? 32'h1 : SEED;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [15:0]     num_q, num_d, sent_q, sent_d, recv_q, recv_d;
    logic [15:0]     pass_q, pass_d, fail_q, fail_d;
    logic            err_q, err_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [31:0]     fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic            fifo_full, fifo_empty, push, pop, clear;
    logic            req_base, resp_base;
    logic [31:0]     op_a, op_b, prod;

    assign op_a       = lfsr_q;
    assign op_b       = {lfsr_q[15:0], lfsr_q[31:16]};
    assign prod       = op_a * op_b;
    assign req_msg    = {op_a, op_b};
    assign fifo_full  = (cnt_q == DepthCnt);
    assign fifo_empty = (cnt_q == '0);
    assign req_base   = (state_q == StRun) && (sent_q < num_q) && !fifo_full;
    assign resp_base  = (state_q == StRun) && !fifo_empty;
    assign push       = req_val & req_rdy;
    assign pop        = resp_val & resp_rdy;
    assign done       = (state_q == StDone);
    assign pass_count = pass_q;
    assign fail_count = fail_q;
    assign error      = err_q;

`ifdef LAB1_IMUL_MSG_DRIVER_STALL_EN
    logic [7:0] lfsr8_q;
    logic       stall, hold_q;

    assign stall = (lfsr8_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr8_q <= 8'h5A;
            hold_q  <= 1'b0;
        end else begin
            lfsr8_q <= {1'b0, lfsr8_q[7:1]} ^ (lfsr8_q[0] ? 8'hB8 : 8'h00);
            hold_q  <= req_val & ~req_rdy;
        end
    end

    // A request already on the wire stays up until taken, regardless of stall.
    assign req_val  = req_base & (~stall | hold_q);
    assign resp_rdy = resp_base & ~stall;
`else
    assign req_val  = req_base;
    assign resp_rdy = resp_base;
`endif

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        sent_d  = sent_q;
        recv_d  = recv_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        err_d   = err_q;
        lfsr_d  = lfsr_q;
        clear   = 1'b0;
        if (push) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrMask : 32'h0);
            sent_d = sent_q + 16'd1;
        end
        if (pop) begin
            recv_d = recv_q + 16'd1;
            if (resp_msg == fifo_q[rptr_q]) begin
                pass_d = pass_q + 16'd1;
            end else begin
                fail_d = fail_q + 16'd1;
                err_d  = 1'b1;
            end
        end
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    num_d   = num_msgs;
                    sent_d  = '0;
                    recv_d  = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    err_d   = 1'b0;
                    clear   = 1'b1;
                    state_d = (num_msgs == 16'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                // Leave on the edge that accepts the final response.
                if (pop && (recv_q + 16'd1 == num_q)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            num_q   <= '0;
            sent_q  <= '0;
            recv_q  <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            err_q   <= 1'b0;
            lfsr_q  <= SeedInit;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            sent_q  <= sent_d;
            recv_q  <= recv_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            lfsr_q  <= lfsr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= prod;
    end

endmodule
